lvds_7to1_rx_align_demap: RTL and testbench

Receive-side counterpart of the LVDS 7:1 video transmitter. It takes the 7-bit words already produced by the deserializers (one clock lane, four data lanes, RGB888) in the pixel clock domain and recovers word alignment from the clock-lane pattern. It then inverts the VESA or JEIDA bit mapping to deliver parallel RGB888 plus HS/VS/DE to the downstream video pipeline.

---
 rtl/lvds_7to1_rx_align_demap.sv | 224 ++++++++++++++++++++++
 tb/tb_lvds_7to1_rx_align_demap.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_7to1_rx_align_demap.sv
`timescale 1ns/1ps
// LVDS 7:1 receive back end: clock-lane word alignment, then VESA/JEIDA demap to RGB888 + HS/VS/DE.
// Latency: word captured at edge n reaches the outputs after edge n+3 (for rotation k, low k bits come from edge n+1).
// Backpressure: none, free-running video; outputs are forced to zero whenever alignment is not locked.
module lvds_7to1_rx_align_demap #(
    parameter int FORMAT     = 0,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        I_pix_clk,
    input  logic        I_rst,
    input  logic [6:0]  I_clk_word,
    input  logic [6:0]  I_data0,
    input  logic [6:0]  I_data1,
    input  logic [6:0]  I_data2,
    input  logic [6:0]  I_data3,
    output logic [7:0]  O_data_r,
    output logic [7:0]  O_data_g,
    output logic [7:0]  O_data_b,
    output logic        O_hs,
    output logic        O_vs,
    output logic        O_de,
    output logic        O_lock,
    output logic [2:0]  O_slip_pos,
    output logic [15:0] O_err_cnt
);

    localparam logic [6:0] CLK_PATTERN = 7'b1100011;
    localparam logic [3:0] LOCK_N      = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N    = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Lane 0 is the clock lane, lanes 1..4 are data0..data3.
    logic [4:0][6:0] cur_d, cur_q;
    logic [4:0][6:0] prev_d, prev_q;
    logic [4:0][6:0] aligned;
    logic [13:0]     win_sh;
    logic [6:0]      a0, a1, a2, a3;
    logic            unused_a3_lsb;

    state_t      state_d, state_q;
    logic        fill_d, fill_q;
    logic [2:0]  k_d, k_q;
    logic [2:0]  k_next;
    logic [3:0]  cnt_d, cnt_q;
    logic [3:0]  miss_d, miss_q;
    logic [15:0] err_d, err_q;
    logic        clk_match;

    logic [7:0]  dm_r, dm_g, dm_b;
    logic        dm_hs, dm_vs, dm_de;
    logic [26:0] pix_d, pix_q;
    logic [26:0] out_pix_d, out_pix_q;
    logic        lock_d, lock_q;

    // Shift the newest words into the two-deep window.
    always_comb begin
        cur_d  = {I_data3, I_data2, I_data1, I_data0, I_clk_word};
        prev_d = cur_q;
    end

    // Window registers: cur holds the newest word, prev the one before it.
    always_ff @(posedge I_pix_clk or posedge I_rst) begin
        if (I_rst) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= cur_d;
            prev_q <= prev_d;
        end
    end

    // Rotate each {prev,cur} window left by k and keep the top 7 bits; k = 0 yields prev.
    always_comb begin
        aligned = '0;
        win_sh  = '0;
        for (int l = 0; l < 5; l++) begin
            win_sh     = {prev_q[l], cur_q[l]} << k_q;
            aligned[l] = win_sh[13:7];
        end
    end

    assign a0            = aligned[1];
    assign a1            = aligned[2];
    assign a2            = aligned[3];
    assign a3            = aligned[4];
    assign unused_a3_lsb = a3[0];

    assign clk_match = (aligned[0] == CLK_PATTERN);
    assign k_next    = (k_q == 3'd6) ? 3'd0 : k_q + 3'd1;

    // Alignment FSM next state: hunt one rotation per cycle, confirm LOCK_CNT matches, tolerate sparse misses.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        err_d   = err_q;
        case (state_q)
            ST_FILL: begin
                // The window is not fully populated until two words have been captured.
                fill_d = 1'b1;
                if (fill_q) begin
                    state_d = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (clk_match) begin
                    state_d = ST_CHECK;
                    cnt_d   = 4'd1;
                end else begin
                    k_d = k_next;
                end
            end
            ST_CHECK: begin
                if (clk_match) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == LOCK_N) begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    state_d = ST_HUNT;
                    k_d     = k_next;
                    cnt_d   = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (clk_match) begin
                    miss_d = 4'd0;
                end else begin
                    miss_d = miss_q + 4'd1;
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    // Drop lock but keep k: a clean stream relocks at the same rotation.
                    if (miss_q + 4'd1 == UNLOCK_N) begin
                        state_d = ST_HUNT;
                        cnt_d   = 4'd0;
                        miss_d  = 4'd0;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Alignment FSM and its counters.
    always_ff @(posedge I_pix_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= ST_FILL;
            fill_q  <= 1'b0;
            k_q     <= 3'd0;
            cnt_q   <= 4'd0;
            miss_q  <= 4'd0;
            err_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    // Invert the transmitter's lane mapping (bit 6 of each lane is the first serial bit).
    always_comb begin
        dm_r  = '0;
        dm_g  = '0;
        dm_b  = '0;
        dm_hs = a2[2];
        dm_vs = a2[1];
        dm_de = a2[0];
        if (FORMAT == 0) begin
            dm_r = {a3[5], a3[6], a0[1], a0[2], a0[3], a0[4], a0[5], a0[6]};
            dm_g = {a3[3], a3[4], a1[2], a1[3], a1[4], a1[5], a1[6], a0[0]};
            dm_b = {a3[1], a3[2], a2[3], a2[4], a2[5], a2[6], a1[0], a1[1]};
        end else begin
            dm_r = {a0[1], a0[2], a0[3], a0[4], a0[5], a0[6], a3[5], a3[6]};
            dm_g = {a1[2], a1[3], a1[4], a1[5], a1[6], a0[0], a3[3], a3[4]};
            dm_b = {a2[3], a2[4], a2[5], a2[6], a1[0], a1[1], a3[1], a3[2]};
        end
        pix_d = {dm_r, dm_g, dm_b, dm_hs, dm_vs, dm_de};
    end

    // Output stage loads the demapped pixel only while locked, so data and O_lock stay cycle-aligned.
    always_comb begin
        lock_d    = (state_q == ST_LOCKED);
        out_pix_d = lock_d ? pix_q : '0;
    end

    // Demap pipeline register and gated output registers.
    always_ff @(posedge I_pix_clk or posedge I_rst) begin
        if (I_rst) begin
            pix_q     <= '0;
            out_pix_q <= '0;
            lock_q    <= 1'b0;
        end else begin
            pix_q     <= pix_d;
            out_pix_q <= out_pix_d;
            lock_q    <= lock_d;
        end
    end

    assign O_data_r   = out_pix_q[26:19];
    assign O_data_g   = out_pix_q[18:11];
    assign O_data_b   = out_pix_q[10:3];
    assign O_hs       = out_pix_q[2];
    assign O_vs       = out_pix_q[1];
    assign O_de       = out_pix_q[0];
    assign O_lock     = lock_q;
    assign O_slip_pos = k_q;
    assign O_err_cnt  = err_q;

endmodule

// File: tb/tb_lvds_7to1_rx_align_demap.sv
`timescale 1ns/1ps
// Bench for lvds_7to1_rx_align_demap: a serial-bit-level transmitter model feeds two receivers (VESA, JEIDA).
// Expected outputs come from the transmitted pixel list and a lock model driven by serial-stream matches.
// No flow control in the design; the bench drives one word set per pixel clock.
module tb_lvds_7to1_rx_align_demap;

    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 4;
    localparam int NTX        = 70;
    localparam int SLEN       = 7 * (NTX + 8);
    localparam logic [26:0] FIXED_PIX = {8'hA5, 8'h3C, 8'h81, 1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] clk_word, d0, d1, d2, d3;

    logic [7:0]  r_v, g_v, b_v, r_j, g_j, b_j;
    logic        hs_v, vs_v, de_v, hs_j, vs_j, de_j;
    logic        lock_v, lock_j;
    logic [2:0]  slip_v, slip_j;
    logic [15:0] err_v, err_j;
    logic [26:0] pix_v, pix_j;

    assign pix_v = {r_v, g_v, b_v, hs_v, vs_v, de_v};
    assign pix_j = {r_j, g_j, b_j, hs_j, vs_j, de_j};

    always #5 clk = ~clk;

    lvds_7to1_rx_align_demap #(.FORMAT(0), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut_v (
        .I_pix_clk(clk), .I_rst(rst), .I_clk_word(clk_word),
        .I_data0(d0), .I_data1(d1), .I_data2(d2), .I_data3(d3),
        .O_data_r(r_v), .O_data_g(g_v), .O_data_b(b_v),
        .O_hs(hs_v), .O_vs(vs_v), .O_de(de_v),
        .O_lock(lock_v), .O_slip_pos(slip_v), .O_err_cnt(err_v)
    );

    lvds_7to1_rx_align_demap #(.FORMAT(1), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut_j (
        .I_pix_clk(clk), .I_rst(rst), .I_clk_word(clk_word),
        .I_data0(d0), .I_data1(d1), .I_data2(d2), .I_data3(d3),
        .O_data_r(r_j), .O_data_g(g_j), .O_data_b(b_j),
        .O_hs(hs_j), .O_vs(vs_j), .O_de(de_j),
        .O_lock(lock_j), .O_slip_pos(slip_j), .O_err_cnt(err_j)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Serial bit stream per lane; rx word for edge e is bits [7e .. 7e+6], first bit in bit 6.
    logic        sbits [5][SLEN];
    logic [26:0] tx_pix [NTX];
    int          s_base;

    // Reference model state (serial-stream view of alignment).
    int m_k, m_fill, m_run, m_miss, m_err, m_pend;
    bit m_locked;
    bit m_exp_lock;
    int m_exp_idx;

    // Forward transmitter mapping, straight from the lane tables.
    function automatic logic [27:0] tx_map(input logic [26:0] p, input bit jeida, input logic x);
        logic [7:0] r, g, b;
        logic hs, vs, de;
        {r, g, b, hs, vs, de} = p;
        if (!jeida)
            return {r[0], r[1], r[2], r[3], r[4], r[5], g[0],
                    g[1], g[2], g[3], g[4], g[5], b[0], b[1],
                    b[2], b[3], b[4], b[5], hs, vs, de,
                    r[6], r[7], g[6], g[7], b[6], b[7], x};
        return {r[2], r[3], r[4], r[5], r[6], r[7], g[2],
                g[3], g[4], g[5], g[6], g[7], b[2], b[3],
                b[4], b[5], b[6], b[7], hs, vs, de,
                r[0], r[1], g[0], g[1], b[0], b[1], x};
    endfunction

    function automatic logic [6:0] get_word(input int lane, input int pos);
        logic [6:0] w;
        for (int i = 0; i < 7; i++) w[6-i] = sbits[lane][pos+i];
        return w;
    endfunction

    task automatic put_word(input int lane, input int pos, input logic [6:0] w);
        for (int i = 0; i < 7; i++) sbits[lane][pos+i] = w[6-i];
    endtask

    task automatic build_stream(input int k0, input bit jeida, input int junk,
                                input int bad_a, input int n_a, input int bad_b, input int n_b,
                                input int fixed_j);
        logic [31:0] rnd;
        logic [27:0] words;
        bit          is_bad;
        for (int l = 0; l < 5; l++)
            for (int i = 0; i < SLEN; i++) sbits[l][i] = 1'b0;
        s_base = 7 + k0;
        for (int j = 0; j < NTX; j++) begin
            rnd = $urandom;
            tx_pix[j] = (j == fixed_j) ? FIXED_PIX : rnd[26:0];
            words = tx_map(tx_pix[j], jeida, 1'($urandom_range(0, 1)));
            is_bad = (j < junk) || (j >= bad_a && j < bad_a + n_a) || (j >= bad_b && j < bad_b + n_b);
            put_word(0, s_base + 7*j, is_bad ? 7'b0000000 : 7'b1100011);
            put_word(1, s_base + 7*j, words[27:21]);
            put_word(2, s_base + 7*j, words[20:14]);
            put_word(3, s_base + 7*j, words[13:7]);
            put_word(4, s_base + 7*j, words[6:0]);
        end
    endtask

    // One clock edge of the reference: outputs reflect the pre-edge lock view, k/err the post-edge one.
    task automatic model_edge(input int e);
        int p, rel;
        bit cm;
        m_exp_lock = m_locked;
        m_exp_idx  = m_locked ? m_pend : -1;
        cm = 1'b0;
        m_pend = -2;
        if (e >= 3) begin
            p   = 7*(e-2) + m_k;
            rel = p - s_base;
            if (rel >= 0 && rel % 7 == 0 && rel / 7 < NTX) m_pend = rel / 7;
            cm = (get_word(0, p) == 7'b1100011);
        end
        if (m_fill < 2) begin
            m_fill++;
        end else if (!m_locked) begin
            if (cm) begin
                m_run++;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
                m_k   = (m_k + 1) % 7;
            end
        end else begin
            if (cm) begin
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_err < 65535) m_err++;
                if (m_miss == UNLOCK_CNT) begin
                    m_locked = 1'b0;
                    m_miss   = 0;
                    m_run    = 0;
                end
            end
        end
    endtask

    task automatic drive_words(input int e);
        clk_word = get_word(0, 7*e);
        d0       = get_word(1, 7*e);
        d1       = get_word(2, 7*e);
        d2       = get_word(3, 7*e);
        d3       = get_word(4, 7*e);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pix_v"}, pix_v, 0);
        check_eq({tag, "_pix_j"}, pix_j, 0);
        check_eq({tag, "_lock"}, {lock_v, lock_j}, 0);
        check_eq({tag, "_slip"}, {slip_v, slip_j}, 0);
        check_eq({tag, "_err"}, {err_v, err_j}, 0);
    endtask

    task automatic run_session(input int sid, input int k0, input bit jeida, input int junk,
                               input int bad_a, input int n_a, input int bad_b, input int n_b,
                               input int fixed_j, input int stop_e, input bit mid_reset);
        logic [26:0] pix_r, pix_w;
        build_stream(k0, jeida, junk, bad_a, n_a, bad_b, n_b, fixed_j);
        rst = 1'b1;
        {clk_word, d0, d1, d2, d3} = '0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        m_k = 0; m_fill = 0; m_run = 0; m_miss = 0; m_err = 0; m_pend = -2; m_locked = 1'b0;
        rst = 1'b0;
        for (int e = 1; e <= stop_e; e++) begin
            drive_words(e);
            @(posedge clk);
            model_edge(e);
            @(negedge clk);
            pix_r = jeida ? pix_j : pix_v;
            pix_w = jeida ? pix_v : pix_j;
            check_eq("lock_v", lock_v, m_exp_lock);
            check_eq("lock_j", lock_j, m_exp_lock);
            check_eq("slip_v", slip_v, m_k);
            check_eq("slip_j", slip_j, m_k);
            check_eq("err_v", err_v, m_err);
            check_eq("err_j", err_j, m_err);
            if (!m_exp_lock) begin
                check_eq("gate_pix_v", pix_v, 0);
                check_eq("gate_pix_j", pix_j, 0);
            end else if (m_exp_idx >= 0) begin
                check_eq("pix", pix_r, tx_pix[m_exp_idx]);
                if (m_exp_idx == fixed_j)
                    check_eq("swap_differs", pix_w != FIXED_PIX, 1);
            end
            if (k0 == 0 && junk == 0 && e == LOCK_CNT + 2) check_eq("lock_before", lock_v, 0);
            if (k0 == 0 && junk == 0 && e == LOCK_CNT + 3) check_eq("lock_edge", lock_v, 1);
            if (k0 == 0 && e == fixed_j + 4) check_eq("fixed_latency", pix_r, FIXED_PIX);
        end
        if (k0 != 0) begin
            check_eq("rot_slip", slip_v, k0);
            check_eq("rot_lock", lock_v, 1);
        end
        if (n_b != 0) check_eq("err_final", err_v, n_a + n_b);
        if (mid_reset) begin
            check_eq("pre_rst_lock", lock_v, 1);
            #2;
            rst = 1'b1;
            #1;
            check_all_zero("arst");
        end
    endtask

    initial begin
        {clk_word, d0, d1, d2, d3} = '0;
        // Aligned VESA stream, fixed pixel, 3 then 4 bad clock words while locked.
        run_session(1, 0, 1'b0, 0, 25, 3, 40, 4, 15, NTX, 1'b0);
        // JEIDA stream offset so k must settle at 3; junk prefix forces k to wrap; reset while locked.
        run_session(2, 3, 1'b1, 12, -100, 0, -100, 0, 30, 60, 1'b1);
        // Relock after the asynchronous reset with the aligned timing.
        run_session(3, 0, 1'b0, 0, -100, 0, -100, 0, 20, 30, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
